pingpong_rd_ctrl: RTL and testbench

PINGPONG_RD_CTRL -- requirements
Module: pingpong_rd_ctrl

---
 rtl/pingpong_rd_ctrl.sv | 143 ++++++++++++++
 tb/tb_pingpong_rd_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pingpong_rd_ctrl
// Description : Read-side controller for a two-bank ping-pong RAM. Synchronizes
//               the write-domain bank-valid flags, reads banks in strict
//               alternation and presents each word on a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module pingpong_rd_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  r_clk,
  input  logic                  n_rst,
  input  logic [1:0]            status_vld,
  input  logic                  read,
  input  logic [DATA_WIDTH-1:0] q,
  input  logic                  dout_rdy,
  output logic                  r_addr,
  output logic [1:0]            r_done,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic                  dout_err,
  output logic                  empty,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_CAPT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
  logic [1:0]                  svld;
  logic [1:0]                  avail;
  logic [1:0]                  consumed_q, consumed_d;
  logic                        rd_ptr_q, rd_ptr_d;
  state_t                      state_q, state_d;
  logic                        r_addr_q, r_addr_d;
  logic [1:0]                  r_done_q, r_done_d;
  logic [DATA_WIDTH-1:0]       dout_q, dout_d;
  logic                        dout_vld_q, dout_vld_d;
  logic                        dout_err_q, dout_err_d;
  logic                        accept;

  // Status flags cross from the write domain; only the last stage is trusted.
  always_comb begin
    sync_d[0] = status_vld;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign svld  = sync_q[SYNC_STAGES-1];
  // A bank is readable only while its writer flags it and we have not yet taken it.
  assign avail = svld & ~consumed_q;

  // Next-state, output and bookkeeping logic for the read transfer.
  always_comb begin
    state_d    = state_q;
    r_addr_d   = r_addr_q;
    r_done_d   = r_done_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    rd_ptr_d   = rd_ptr_q;
    accept     = 1'b0;
    // Any read that does not launch a transfer is rejected, including reads while busy.
    dout_err_d = read && !((state_q == ST_IDLE) && avail[rd_ptr_q]);

    case (state_q)
      ST_IDLE: begin
        if (read && avail[rd_ptr_q]) begin
          state_d  = ST_ADDR;
          r_addr_d = rd_ptr_q;
        end
      end
      ST_ADDR: begin
        state_d = ST_CAPT;
      end
      ST_CAPT: begin
        dout_d     = q;
        dout_vld_d = 1'b1;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        if (dout_rdy) begin
          accept             = 1'b1;
          dout_vld_d         = 1'b0;
          r_done_d[r_addr_q] = ~r_done_q[r_addr_q];
          rd_ptr_d           = ~rd_ptr_q;
          state_d            = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Consumed marks persist until the writer drops the flag; a drop always wins.
    consumed_d = consumed_q;
    if (accept) begin
      consumed_d[r_addr_q] = 1'b1;
    end
    consumed_d = consumed_d & svld;
  end

  // All state registers, cleared asynchronously by n_rst.
  always_ff @(posedge r_clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q     <= '0;
      consumed_q <= 2'b00;
      rd_ptr_q   <= 1'b0;
      state_q    <= ST_IDLE;
      r_addr_q   <= 1'b0;
      r_done_q   <= 2'b00;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      dout_err_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      consumed_q <= consumed_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      r_addr_q   <= r_addr_d;
      r_done_q   <= r_done_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      dout_err_q <= dout_err_d;
    end
  end

  assign r_addr   = r_addr_q;
  assign r_done   = r_done_q;
  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign dout_err = dout_err_q;
  assign empty    = ~|avail;
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pingpong_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pingpong_rd_ctrl
// Description : Bench for pingpong_rd_ctrl; a cycle-indexed transaction model
//               predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pingpong_rd_ctrl;
  localparam int DW = 8;
  localparam int S  = 2;

  logic          r_clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [1:0]    status_vld = 2'b00;
  logic          read = 1'b0;
  logic          dout_rdy = 1'b0;
  logic [DW-1:0] q;
  logic          r_addr;
  logic [1:0]    r_done;
  logic [DW-1:0] dout;
  logic          dout_vld, dout_err, empty, busy;

  pingpong_rd_ctrl #(.DATA_WIDTH(DW), .SYNC_STAGES(S)) dut (
    .r_clk(r_clk), .n_rst(n_rst), .status_vld(status_vld), .read(read),
    .q(q), .dout_rdy(dout_rdy), .r_addr(r_addr), .r_done(r_done),
    .dout(dout), .dout_vld(dout_vld), .dout_err(dout_err),
    .empty(empty), .busy(busy)
  );

  always #5 r_clk = ~r_clk;

  // Two-word RAM with one-cycle read latency.
  logic [DW-1:0] mem [2];
  always @(posedge r_clk) q <= mem[r_addr];

  int tests = 0;
  int fails = 0;

  // Model state: transfers described by their start cycle and bank.
  int         cyc = 0;
  int         rel = 0;
  logic [1:0] hist [0:4095];
  logic [1:0] m_cons;
  logic       m_ptr;
  bit         m_act;
  int         m_T;
  logic       m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_dout;
  logic [1:0] m_done;
  bit         m_err;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Flags seen by the reader lag the writer by S cycles and read as 0 until S cycles after reset release.
  function automatic logic [1:0] svld_at(int c);
    if (c - S < rel) return 2'b00;
    return hist[c-S];
  endfunction

  task automatic model_reset(int release_cycle);
    rel    = release_cycle;
    m_cons = 2'b00;
    m_ptr  = 1'b0;
    m_act  = 1'b0;
    m_T    = 0;
    m_addr = 1'b0;
    m_data = '0;
    m_dout = '0;
    m_done = 2'b00;
    m_err  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_r_addr",   32'(r_addr),   32'd0);
    chk("rst_r_done",   32'(r_done),   32'd0);
    chk("rst_dout",     32'(dout),     32'd0);
    chk("rst_dout_vld", 32'(dout_vld), 32'd0);
    chk("rst_dout_err", 32'(dout_err), 32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
  endtask

  task automatic check_cycle();
    logic [1:0] av;
    bit showing;
    av      = svld_at(cyc) & ~m_cons;
    showing = m_act && (cyc >= m_T + 3);
    chk("busy",     32'(busy),     32'(m_act));
    chk("dout_vld", 32'(dout_vld), 32'(showing));
    chk("dout",     32'(dout),     32'(showing ? m_data : m_dout));
    chk("r_addr",   32'(r_addr),   32'(m_addr));
    chk("r_done",   32'(r_done),   32'(m_done));
    chk("dout_err", 32'(dout_err), 32'(m_err));
    chk("empty",    32'(empty),    32'(av == 2'b00));
  endtask

  task automatic model_update(bit rd, bit rdy);
    logic [1:0] sv, av;
    bit acc;
    sv    = svld_at(cyc);
    av    = sv & ~m_cons;
    acc   = m_act && (cyc >= m_T + 3) && rdy;
    m_err = 1'b0;
    if (rd) begin
      if (!m_act && av[m_ptr]) begin
        m_act  = 1'b1;
        m_T    = cyc;
        m_addr = m_ptr;
        m_data = mem[m_ptr];
      end else begin
        m_err = 1'b1;
      end
    end
    if (acc) begin
      m_done[m_addr] = ~m_done[m_addr];
      m_cons[m_addr] = 1'b1;
      m_ptr          = ~m_ptr;
      m_dout         = m_data;
      m_act          = 1'b0;
    end
    m_cons = m_cons & sv;
  endtask

  // One clock cycle: check outputs, then drive this cycle's inputs.
  task automatic step(bit rd, bit rdy, logic [1:0] sv, bit rst_after = 1'b0);
    @(negedge r_clk);
    check_cycle();
    n_rst      = 1'b1;
    read       = rd;
    dout_rdy   = rdy;
    status_vld = sv;
    hist[cyc]  = sv;
    model_update(rd, rdy);
    if (rst_after) begin
      #1 n_rst = 1'b0;
      #1 check_reset_outputs();
      model_reset(cyc + 1);
    end
    cyc++;
  endtask

  task automatic idle(int n, logic [1:0] sv);
    repeat (n) step(1'b0, 1'b1, sv);
  endtask

  logic [1:0] sv_r;

  initial begin
    mem[0] = 8'h00;
    mem[1] = 8'h00;
    model_reset(0);
    #1 check_reset_outputs();

    // Single read of bank 0 accepted immediately.
    mem[0] = 8'hA5;
    idle(4, 2'b01);
    step(1'b1, 1'b1, 2'b01);
    idle(5, 2'b01);

    // Both banks: 8'h12 then 8'h34 from a fresh pointer.
    step(1'b0, 1'b1, 2'b01, 1'b1);
    mem[0] = 8'h12;
    mem[1] = 8'h34;
    idle(4, 2'b11);
    step(1'b1, 1'b1, 2'b11);
    idle(5, 2'b11);
    step(1'b1, 1'b1, 2'b11);
    idle(5, 2'b11);

    // Nothing valid: rejected read.
    idle(4, 2'b00);
    step(1'b1, 1'b1, 2'b00);
    idle(3, 2'b00);

    // Held output with a rejected read mid-hold.
    step(1'b0, 1'b1, 2'b00, 1'b1);
    mem[0] = 8'h5C;
    idle(4, 2'b01);
    step(1'b1, 1'b0, 2'b01);
    repeat (3) step(1'b0, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b01);
    repeat (3) step(1'b0, 1'b0, 2'b01);
    step(1'b0, 1'b1, 2'b01);
    idle(3, 2'b01);

    // Consumed bank stays unavailable until its flag cycles 0 then 1.
    step(1'b1, 1'b1, 2'b01);
    idle(3, 2'b01);
    mem[0] = 8'hC3;
    mem[1] = 8'h7E;
    idle(4, 2'b10);
    idle(4, 2'b11);
    step(1'b1, 1'b1, 2'b11);
    idle(5, 2'b11);
    step(1'b1, 1'b1, 2'b11);
    idle(5, 2'b11);

    // Reset during hold, then a fresh read targets bank 0.
    idle(4, 2'b00);
    idle(4, 2'b11);
    step(1'b1, 1'b0, 2'b11);
    idle(0, 2'b11);
    repeat (3) step(1'b0, 1'b0, 2'b11);
    step(1'b0, 1'b0, 2'b11, 1'b1);
    idle(4, 2'b11);
    step(1'b1, 1'b1, 2'b11);
    idle(5, 2'b11);

    // Random traffic.
    sv_r = 2'b11;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) sv_r = 2'($urandom);
      if (!m_act) mem[$urandom_range(0, 1)] = 8'($urandom);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, sv_r);
    end
    idle(2, sv_r);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
